// File: rtl/sweep_sched.sv
// Frequency sweep scheduler: steps a DDS tuning word from fre_start to fre_end,
// waits for settling and one measurement per point, then reports completion.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, abort          sweep start pulse / abort level
//   fre_start, fre_end    first and last allowed tuning word
//   step, dwell           tuning-word increment / measurement timeout (0 = none)
//   meas_done             measurement-complete pulse
//   fre_k                 tuning word to the phase accumulator
//   meas_req, busy        measurement request / sweep active
//   sweep_done, cfg_err   end-of-sweep pulse / rejected-start pulse
//   point_idx, timeout    current point index (saturating) / sticky timeout flag
module sweep_sched #(
    parameter int FW            = 32,
    parameter int SETTLE_CYCLES = 1024,
    parameter int IDX_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [FW-1:0]    fre_start,
    input  logic [FW-1:0]    fre_end,
    input  logic [FW-1:0]    step,
    input  logic [31:0]      dwell,
    input  logic             meas_done,
    output logic [FW-1:0]    fre_k,
    output logic             meas_req,
    output logic             busy,
    output logic             sweep_done,
    output logic [IDX_W-1:0] point_idx,
    output logic             timeout,
    output logic             cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_STEP,
        S_DONE
    } state_t;

    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [FW-1:0]    r_fk;
    logic [FW-1:0]    r_end;
    logic [FW-1:0]    r_step;
    logic [31:0]      r_dwell;
    logic [31:0]      r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             r_to;
    logic             r_cerr;

    logic [FW:0]      w_next;
    logic             w_load;
    logic             w_cerr;
    logic             w_adv;
    logic             w_to;
    logic             w_cnt_clr;
    logic             w_cnt_inc;

    // One extra bit so a wrap past all-ones ends the sweep instead of restarting low.
    assign w_next = {1'b0, r_fk} + {1'b0, r_step};

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_cerr      = 1'b0;
        w_adv       = 1'b0;
        w_to        = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    if (fre_start > fre_end) begin
                        w_cerr = 1'b1;
                    end else begin
                        w_load      = 1'b1;
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == SETTLE_LAST) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_MEASURE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_MEASURE: begin
                // A completion arriving on the expiry cycle wins over the timeout.
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (meas_done) begin
                    w_state_nxt = S_STEP;
                end else if (r_dwell != 32'd0 &&
                             r_cnt == r_dwell - 32'd1) begin
                    w_to        = 1'b1;
                    w_state_nxt = S_STEP;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_STEP: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_next[FW] || w_next[FW-1:0] > r_end ||
                             r_step == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_adv       = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_SETTLE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fk    <= '0;
            r_end   <= '0;
            r_step  <= '0;
            r_dwell <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_to    <= 1'b0;
            r_cerr  <= 1'b0;
        end else begin
            r_cerr <= w_cerr;
            if (w_load) begin
                r_fk    <= fre_start;
                r_end   <= fre_end;
                r_step  <= step;
                r_dwell <= dwell;
                r_idx   <= '0;
                r_to    <= 1'b0;
            end
            if (w_adv) begin
                r_fk <= w_next[FW-1:0];
                if (r_idx != '1) begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
            if (w_to) begin
                r_to <= 1'b1;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    assign fre_k      = r_fk;
    assign point_idx  = r_idx;
    assign timeout    = r_to;
    assign cfg_err    = r_cerr;
    assign meas_req   = (r_state == S_MEASURE);
    assign sweep_done = (r_state == S_DONE);
    assign busy       = (r_state == S_SETTLE) || (r_state == S_MEASURE) ||
                        (r_state == S_STEP);

endmodule

// File: tb/tb_sweep_sched.sv
// Testbench for sweep_sched: procedural sweep model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sweep_sched;

    localparam int SC = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          meas_done = 1'b0;
    logic [31:0]   fre_start = '0;
    logic [31:0]   fre_end = '0;
    logic [31:0]   step = '0;
    logic [31:0]   dwell = '0;
    logic [31:0]   fre_k;
    logic          meas_req;
    logic          busy;
    logic          sweep_done;
    logic [IW-1:0] point_idx;
    logic          timeout;
    logic          cfg_err;

    sweep_sched #(
        .FW(32),
        .SETTLE_CYCLES(SC),
        .IDX_W(IW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .fre_start(fre_start),
        .fre_end(fre_end),
        .step(step),
        .dwell(dwell),
        .meas_done(meas_done),
        .fre_k(fre_k),
        .meas_req(meas_req),
        .busy(busy),
        .sweep_done(sweep_done),
        .point_idx(point_idx),
        .timeout(timeout),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [32:0] act,
                       input logic [32:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [31:0] m_fk = '0;
    int          m_idx = 0;
    bit          m_busy = 0;
    bit          m_req = 0;
    bit          m_done = 0;
    bit          m_to = 0;
    bit          m_cerr = 0;
    bit          m_kill = 0;

    task automatic tick();
        @(posedge clk);
        m_done = 0;
        m_cerr = 0;
        m_kill = (rst_n == 1'b0);
        if (m_kill) begin
            m_fk = '0;
            m_idx = 0;
            m_busy = 0;
            m_req = 0;
            m_to = 0;
        end
    endtask

    task automatic run_sweep();
        logic [31:0] fe;
        logic [31:0] st;
        logic [31:0] dw;
        logic [32:0] nx;
        int n;
        fe = fre_end;
        st = step;
        dw = dwell;
        m_fk = fre_start;
        m_idx = 0;
        m_to = 0;
        m_busy = 1;
        m_req = 0;
        forever begin
            for (int i = 0; i < SC; i++) begin
                tick();
                if (m_kill) return;
                if (abort) begin m_busy = 0; return; end
            end
            m_req = 1;
            n = 0;
            forever begin
                tick();
                if (m_kill) return;
                if (abort) begin m_busy = 0; m_req = 0; return; end
                n++;
                if (meas_done) break;
                if (dw != 0 && n == int'(dw)) begin m_to = 1; break; end
            end
            m_req = 0;
            tick();
            if (m_kill) return;
            if (abort) begin m_busy = 0; return; end
            nx = {1'b0, m_fk} + {1'b0, st};
            if (nx[32] || nx[31:0] > fe || st == 0) begin
                m_busy = 0;
                m_done = 1;
                tick();
                return;
            end
            m_fk = nx[31:0];
            if (m_idx < (1 << IW) - 1) m_idx++;
        end
    endtask

    initial begin : model
        forever begin
            tick();
            if (!m_kill && start && !abort) begin
                if (fre_start > fre_end) m_cerr = 1;
                else run_sweep();
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("fre_k", {1'b0, fre_k}, {1'b0, m_fk});
        chk("point_idx", 33'(point_idx), 33'(m_idx[IW-1:0]));
        chk("busy", 33'(busy), 33'(m_busy));
        chk("meas_req", 33'(meas_req), 33'(m_req));
        chk("sweep_done", 33'(sweep_done), 33'(m_done));
        chk("timeout", 33'(timeout), 33'(m_to));
        chk("cfg_err", 33'(cfg_err), 33'(m_cerr));
    end

    // ---------------- measurement responder ----------------
    int resp_lat = 0;
    bit spur = 0;
    int mc = 0;

    always @(negedge clk) begin
        if (meas_req) mc++;
        else mc = 0;
        meas_done = (meas_req && resp_lat > 0 && mc == resp_lat) ||
                    (spur && !meas_req);
    end

    // ---------------- monitor ----------------
    int          n_rise = 0;
    int          n_reqhi = 0;
    int          n_done = 0;
    int          n_cerr = 0;
    int          n_busy = 0;
    logic        prev_req = 1'b0;
    logic [31:0] q_fk[$];
    int          q_idx[$];

    always @(negedge clk) begin
        if (meas_req && !prev_req) begin
            n_rise++;
            q_fk.push_back(fre_k);
            q_idx.push_back(int'(point_idx));
        end
        if (meas_req) n_reqhi++;
        if (sweep_done) n_done++;
        if (cfg_err) n_cerr++;
        if (busy) n_busy++;
        prev_req = meas_req;
    end

    // ---------------- stimulus ----------------
    task automatic go(input logic [31:0] fs, input logic [31:0] fe,
                      input logic [31:0] st, input logic [31:0] dw);
        @(negedge clk);
        fre_start = fs;
        fre_end = fe;
        step = st;
        dwell = dw;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({"idle_", nm}, 33'(busy), 33'd0);
        @(negedge clk);
        #2;
    endtask

    int b, r0, h0, d0, c0, u0, k;

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        repeat (3) @(negedge clk);
        #2;
        chk("rst_fre_k", {1'b0, fre_k}, 33'd0);
        chk("rst_busy", 33'(busy), 33'd0);
        chk("rst_idx", 33'(point_idx), 33'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // normal sweep, mid-sweep input changes and a start while busy
        resp_lat = 3;
        b = q_fk.size(); d0 = n_done; c0 = n_cerr;
        go(32'd100, 32'd130, 32'd10, 32'd50);
        fre_start = 32'd7; fre_end = 32'd0; step = 32'd1; dwell = 32'd1;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(200, "normal");
        chk("norm_points", 33'(q_fk.size() - b), 33'd4);
        for (int i = 0; i < 4; i++) begin
            chk("norm_fk", {1'b0, q_fk[b + i]}, 33'(100 + 10 * i));
            chk("norm_idx", 33'(q_idx[b + i]), 33'(i));
        end
        chk("norm_done", 33'(n_done - d0), 33'd1);
        chk("norm_cerr", 33'(n_cerr - c0), 33'd0);
        chk("norm_to", 33'(timeout), 33'd0);
        chk("norm_last", {1'b0, fre_k}, 33'd130);

        // timeout: no meas_done at all
        resp_lat = 0;
        h0 = n_reqhi; d0 = n_done; r0 = n_rise;
        go(32'd5, 32'd5, 32'd1, 32'd8);
        wait_idle(100, "timeout");
        chk("to_reqhi", 33'(n_reqhi - h0), 33'd8);
        chk("to_points", 33'(n_rise - r0), 33'd1);
        chk("to_flag", 33'(timeout), 33'd1);
        chk("to_done", 33'(n_done - d0), 33'd1);

        // meas_done on the expiry cycle counts as done
        resp_lat = 8;
        h0 = n_reqhi;
        go(32'd5, 32'd5, 32'd1, 32'd8);
        wait_idle(100, "simul");
        chk("sim_reqhi", 33'(n_reqhi - h0), 33'd8);
        chk("sim_to", 33'(timeout), 33'd0);

        // configuration error
        c0 = n_cerr; u0 = n_busy;
        go(32'd200, 32'd100, 32'd10, 32'd50);
        repeat (3) @(negedge clk);
        #2;
        chk("cfg_pulse", 33'(n_cerr - c0), 33'd1);
        chk("cfg_busy", 33'(n_busy - u0), 33'd0);

        // carry out of the top ends the sweep after one point
        resp_lat = 1;
        r0 = n_rise; d0 = n_done;
        go(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd32, 32'd50);
        wait_idle(100, "carry");
        chk("cy_points", 33'(n_rise - r0), 33'd1);
        chk("cy_done", 33'(n_done - d0), 33'd1);
        chk("cy_fk", {1'b0, fre_k}, 33'h0_FFFF_FFF0);

        // abort on the second MEASURE cycle of point 1
        resp_lat = 5;
        d0 = n_done;
        go(32'd100, 32'd130, 32'd10, 32'd50);
        k = 0;
        while (!(meas_req && point_idx == 1) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("ab_found", 33'(meas_req && point_idx == 1), 33'd1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #2;
        chk("ab_req", 33'(meas_req), 33'd0);
        chk("ab_busy", 33'(busy), 33'd0);
        chk("ab_fk", {1'b0, fre_k}, 33'd110);
        repeat (3) @(negedge clk);
        #2;
        chk("ab_nodone", 33'(n_done - d0), 33'd0);

        // asynchronous reset in SETTLE, then a clean sweep
        resp_lat = 3;
        d0 = n_done;
        go(32'd100, 32'd130, 32'd10, 32'd50);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_fk", {1'b0, fre_k}, 33'd0);
        chk("ar_busy", 33'(busy), 33'd0);
        chk("ar_req", 33'(meas_req), 33'd0);
        chk("ar_idx", 33'(point_idx), 33'd0);
        chk("ar_to", 33'(timeout), 33'd0);
        chk("ar_sd", 33'(sweep_done), 33'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("ar_nodone", 33'(n_done - d0), 33'd0);
        b = q_fk.size(); d0 = n_done;
        go(32'd100, 32'd130, 32'd10, 32'd50);
        wait_idle(200, "after_rst");
        chk("ar_points", 33'(q_fk.size() - b), 33'd4);
        for (int i = 0; i < 4; i++) begin
            chk("ar_seq", {1'b0, q_fk[b + i]}, 33'(100 + 10 * i));
        end
        chk("ar_done", 33'(n_done - d0), 33'd1);

        // index saturation, stray meas_done outside MEASURE
        resp_lat = 2;
        spur = 1;
        b = q_fk.size();
        go(32'd0, 32'd50, 32'd10, 32'd20);
        wait_idle(400, "sat");
        spur = 0;
        chk("sat_points", 33'(q_fk.size() - b), 33'd6);
        chk("sat_idx4", 33'(q_idx[b + 4]), 33'd3);
        chk("sat_idx5", 33'(q_idx[b + 5]), 33'd3);
        chk("sat_fk", {1'b0, fre_k}, 33'd50);
        chk("sat_to", 33'(timeout), 33'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sweep_sched.md
SWEEP_SCHED -- requirements
Module: sweep_sched

Interface
REQ-001 SHALL have parameter FW, default 32: width of frequency tuning words and step.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 1024: wait in cycles after each tuning-word change before measurement.
REQ-003 SHALL have parameter IDX_W, default 16: width of the point counter.
REQ-004 clk  input  1  single clock, which also drives the phase accumulator.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse that begins a sweep.
REQ-007 abort  input  1  level; stops the sweep.
REQ-008 fre_start  input  FW  first tuning word.
REQ-009 fre_end  input  FW  last allowed tuning word.
REQ-010 step  input  FW  tuning-word increment.
REQ-011 dwell  input  32  measurement timeout per point, in cycles.
REQ-012 meas_done  input  1  one-cycle pulse from the counter block: measurement complete.
REQ-013 fre_k  output  FW  tuning word to the accumulator.
REQ-014 meas_req  output  1  level requesting a measurement.
REQ-015 busy  output  1  high while a sweep is active.
REQ-016 sweep_done  output  1  one-cycle end-of-sweep pulse.
REQ-017 point_idx  output  IDX_W  index of the current point.
REQ-018 timeout  output  1  sticky flag: a point timed out during the current sweep.
REQ-019 cfg_err  output  1  one-cycle pulse: start was rejected.

Function
REQ-020 SHALL implement FSM states IDLE, SETTLE, MEASURE, STEP, DONE.
REQ-021 IDLE, start=1: SHALL check the configuration.
- If fre_start > fre_end: pulse cfg_err and stay in IDLE.
- Otherwise: latch fre_start/fre_end/step/dwell, set fre_k=fre_start, point_idx=0, clear timeout, go to SETTLE next cycle.
REQ-022 SHALL ignore start while busy.
REQ-023 SETTLE: SHALL count SETTLE_CYCLES cycles, then enter MEASURE; meas_req SHALL rise on the first MEASURE cycle.
REQ-024 MEASURE: SHALL hold meas_req=1 and count cycles.
- meas_done=1: drop meas_req the next cycle and go to STEP.
- Count reaches latched dwell with no meas_done: set timeout and go to STEP.
- dwell=0: no timeout; wait indefinitely.
REQ-025 meas_done and timeout expiry in the same cycle: SHALL count as done; timeout SHALL NOT be set.
REQ-026 SHALL ignore meas_done outside MEASURE.
REQ-027 STEP (one cycle): SHALL compute next = fre_k + step at FW+1 bits.
- next > fre_end, carry set, or step=0: go to DONE.
- Otherwise: fre_k=next, point_idx+1, go to SETTLE.
REQ-028 DONE: SHALL pulse sweep_done for one cycle and return to IDLE; fre_k SHALL hold the last swept value.
REQ-029 busy SHALL be 1 in SETTLE, MEASURE and STEP; 0 in IDLE and DONE.
REQ-030 point_idx SHALL saturate at all-ones; the sweep SHALL continue.
REQ-031 abort=1 in any busy state: SHALL go to IDLE next cycle, drop meas_req, and NOT pulse sweep_done. fre_k SHALL hold. abort beats start in the same cycle.
REQ-032 fre_start = fre_end: SHALL sweep exactly one point.
REQ-033 Latched configuration SHALL NOT change mid-sweep; input changes take effect at the next start.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE with all outputs 0: fre_k, meas_req, busy, sweep_done, point_idx, timeout, cfg_err. Counters SHALL clear.
REQ-035 Reset release SHALL take effect synchronously on the first clk edge after deassertion; reset mid-sweep SHALL abandon the sweep with no done pulse.

Verification (SETTLE_CYCLES=4 for bench)
REQ-036 Normal sweep: start=100, end=130, step=10, dwell=50, meas_done 3 cycles after each meas_req.
- fre_k sequence 100, 110, 120, 130; point_idx 0..3.
- One sweep_done pulse; timeout=0.
REQ-037 Timeout: dwell=8, meas_done never asserted, start=end=5 -> meas_req high exactly 8 cycles, timeout=1, sweep_done pulses, busy falls.
REQ-038 Config error and overflow:
- start=200, end=100 -> cfg_err pulse; busy stays 0.
- start=32'hFFFF_FFF0, end=32'hFFFF_FFFF, step=32 -> one point, then DONE (carry).
REQ-039 Abort: abort pulse on the second MEASURE cycle of point 1 -> IDLE next cycle, meas_req=0, no sweep_done, fre_k holds point-1 value.
REQ-040 Reset mid-SETTLE: rst_n low asynchronously -> all outputs 0 before the next clk edge; a later start runs the sweep normally.
REQ-041 Simultaneous events: meas_done on the same cycle as dwell expiry -> timeout stays 0; start asserted while busy -> ignored, sequence unchanged.
